// File: rtl/adc_multi_average.sv
`default_nettype none
// ============================================================================
//  Module   : adc_multi_average
//  Brief    : Block averager for NUM_CH parallel ADC channels. Sums 2^LOG2_SAMPS
//             accepted sample sets per channel, then emits the rounded
//             (half-up) mean of each channel with a one-cycle DONE pulse.
//             Supports single-shot (START) and continuous (CONT) operation.
//  Revision : 1.0 - initial release
// ============================================================================
module adc_multi_average #(
  parameter int ADC_WIDTH   = 12,
  parameter int NUM_CH      = 2,
  parameter int LOG2_SAMPS  = 10,
  parameter bit SIGNED_MODE = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*ADC_WIDTH-1:0] data_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        start,
  input  logic                        cont,
  output logic                        busy,
  output logic [NUM_CH*ADC_WIDTH-1:0] data_out,
  output logic                        done
);

  // Accumulator is wide enough that 2^LOG2_SAMPS full-scale samples never wrap.
  localparam int ACC_W = ADC_WIDTH + LOG2_SAMPS;
  localparam logic [LOG2_SAMPS-1:0] CNT_ONE = LOG2_SAMPS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                  state;
  logic [LOG2_SAMPS-1:0]   samp_cnt;
  logic [ACC_W-1:0]        acc        [NUM_CH];
  logic [ACC_W-1:0]        sample_ext [NUM_CH];
  logic [ADC_WIDTH-1:0]    rounded    [NUM_CH];
  logic                    accept;
  logic                    last_samp;

  assign accept    = in_valid & in_ready;
  // Counter wraps to zero on the Nth accept, so all-ones marks the last sample.
  assign last_samp = &samp_cnt;

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [ADC_WIDTH-1:0] samp;
      assign samp = data_in[c*ADC_WIDTH +: ADC_WIDTH];

      if (SIGNED_MODE) begin : g_signed
        assign sample_ext[c] = {{LOG2_SAMPS{samp[ADC_WIDTH-1]}}, samp};
      end else begin : g_unsigned
        assign sample_ext[c] = {{LOG2_SAMPS{1'b0}}, samp};
      end

      // Adding 2^(LOG2_SAMPS-1) before the shift only carries into the kept
      // bits when bit LOG2_SAMPS-1 is set, so the round-half-up shift reduces
      // to "upper bits plus that bit". Modulo-2^ADC_WIDTH arithmetic gives the
      // arithmetic-shift result in signed mode as well.
      assign rounded[c] = acc[c][ACC_W-1:LOG2_SAMPS]
                        + {{(ADC_WIDTH-1){1'b0}}, acc[c][LOG2_SAMPS-1]};
    end
  endgenerate

  // Control FSM with accumulators, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      samp_cnt <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start || cont) begin
            state    <= S_ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            samp_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              acc[c] <= '0;
            end
          end
        end

        S_ACCUM: begin
          if (accept) begin
            samp_cnt <= samp_cnt + CNT_ONE;
            for (int c = 0; c < NUM_CH; c++) begin
              acc[c] <= acc[c] + sample_ext[c];
            end
            if (last_samp) begin
              state    <= S_LATCH;
              in_ready <= 1'b0;
            end
          end
        end

        S_LATCH: begin
          // Result is published here; START is deliberately not looked at.
          done <= 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            data_out[c*ADC_WIDTH +: ADC_WIDTH] <= rounded[c];
          end
          if (cont) begin
            state    <= S_ACCUM;
            in_ready <= 1'b1;
            samp_cnt <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
              acc[c] <= '0;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_multi_average.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_multi_average
//  Brief    : Self-checking bench for adc_multi_average. Two groups of DUTs:
//             group 0 (N=1024, unsigned + signed) for long block scenarios,
//             group 1 (N=4, unsigned + signed) for table-driven vectors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adc_multi_average;

  localparam int W   = 12;
  localparam int NCH = 2;
  localparam int LA  = 10;
  localparam int LB  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NCH*W-1:0]   data_in;
  logic               in_valid;
  logic               start_a, cont_a, start_b, cont_b;
  logic [3:0]         rdy, bsy, dn;
  logic [NCH*W-1:0]   dout [4];

  adc_multi_average #(.ADC_WIDTH(W), .NUM_CH(NCH), .LOG2_SAMPS(LA), .SIGNED_MODE(1'b0)) u_a_uns (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[0]),
    .start(start_a), .cont(cont_a), .busy(bsy[0]), .data_out(dout[0]), .done(dn[0]));
  adc_multi_average #(.ADC_WIDTH(W), .NUM_CH(NCH), .LOG2_SAMPS(LA), .SIGNED_MODE(1'b1)) u_a_sgn (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[1]),
    .start(start_a), .cont(cont_a), .busy(bsy[1]), .data_out(dout[1]), .done(dn[1]));
  adc_multi_average #(.ADC_WIDTH(W), .NUM_CH(NCH), .LOG2_SAMPS(LB), .SIGNED_MODE(1'b0)) u_b_uns (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[2]),
    .start(start_b), .cont(cont_b), .busy(bsy[2]), .data_out(dout[2]), .done(dn[2]));
  adc_multi_average #(.ADC_WIDTH(W), .NUM_CH(NCH), .LOG2_SAMPS(LB), .SIGNED_MODE(1'b1)) u_b_sgn (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .in_valid(in_valid), .in_ready(rdy[3]),
    .start(start_b), .cont(cont_b), .busy(bsy[3]), .data_out(dout[3]), .done(dn[3]));

  int checks = 0;
  int errors = 0;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NCH*W-1:0] data;
    longint           cyc;
  } exp_t;

  exp_t             sq [4][$];
  logic [NCH*W-1:0] last_exp [4];

  typedef struct {
    logic [W-1:0]     a [4];
    logic [W-1:0]     b [4];
    logic [NCH*W-1:0] exp_u;
    logic [NCH*W-1:0] exp_s;
  } vec_t;
  vec_t tbl [6];

  // stimulus pattern state
  int           pat;    // 0 const, 1 step, 2 table, 3 random
  int           tsel;
  int           vmode;  // 0 valid always, 1 valid every other cycle
  logic [W-1:0] k0, k1;
  longint       sum_u [2][NCH];
  longint       sum_s [2][NCH];
  int           cnt   [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int blk_n(input int g);
    return (g == 0) ? (1 << LA) : (1 << LB);
  endfunction

  function automatic logic [W-1:0] avg(input longint sum, input int l);
    longint r;
    r = (sum + (longint'(1) << (l - 1))) >>> l;
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] sample(input int g, input int c, input int idx);
    case (pat)
      0:       return (c == 0) ? k0 : k1;
      1:       return (c == 0) ? ((idx < blk_n(g) / 2) ? 12'h7FF : 12'h800) : k1;
      2:       return (c == 0) ? tbl[tsel].a[idx] : tbl[tsel].b[idx];
      default: return W'($urandom);
    endcase
  endfunction

  // push expected results for both DUTs of group g; done follows 2 edges later
  task automatic push_block(input int g);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (pat == 2) begin
        e.data = (k == 0) ? tbl[tsel].exp_u : tbl[tsel].exp_s;
      end else begin
        for (int c = 0; c < NCH; c++)
          e.data[c*W +: W] = avg((k == 0) ? sum_u[g][c] : sum_s[g][c], (g == 0) ? LA : LB);
      end
      e.cyc = cyc + 2;
      sq[2*g + k].push_back(e);
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < 2; g++) begin
      cnt[g] = 0;
      for (int c = 0; c < NCH; c++) begin
        sum_u[g][c] = 0;
        sum_s[g][c] = 0;
      end
    end
  endtask

  // offer samples until n are accepted by group g; returns refused-offer count
  task automatic feed(input int g, input int n, output int stalls);
    int got;
    int budget;
    logic [W-1:0] s [NCH];
    got = 0; budget = 0; stalls = 0;
    while (got < n && budget < 4*n + 20) begin
      @(negedge clk);
      budget++;
      for (int c = 0; c < NCH; c++) s[c] = sample(g, c, cnt[g]);
      data_in  = {s[1], s[0]};
      in_valid = (vmode == 0) ? 1'b1 : budget[0];
      if (in_valid) begin
        if (rdy[2*g]) begin
          got++;
          for (int c = 0; c < NCH; c++) begin
            sum_u[g][c] += longint'(s[c]);
            sum_s[g][c] += longint'($signed(s[c]));
          end
          cnt[g]++;
          if (cnt[g] == blk_n(g)) begin
            push_block(g);
            cnt[g] = 0;
            for (int c = 0; c < NCH; c++) begin
              sum_u[g][c] = 0;
              sum_s[g][c] = 0;
            end
          end
        end else begin
          stalls++;
        end
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL feed_timeout accepted=%0d required=%0d", got, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    if (g == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard consumer: every DONE pops one expectation for that DUT
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (rst_n === 1'b1 && dn[d] === 1'b1) begin
        if (sq[d].size() == 0) begin
          checks++; errors++;
          $display("FAIL dut%0d_unexpected_done actual=%0h required=no_done", d, dout[d]);
        end else begin
          e = sq[d].pop_front();
          chk($sformatf("dut%0d_data", d), 64'(dout[d]), 64'(e.data));
          chk($sformatf("dut%0d_done_cycle", d), 64'(cyc), 64'(e.cyc));
          last_exp[d] = e.data;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2;
    tbl[0] = '{a:'{12'h000,12'h000,12'h000,12'h000}, b:'{12'hFFF,12'hFFF,12'hFFF,12'hFFF}, exp_u:24'hFFF000, exp_s:24'hFFF000};
    tbl[1] = '{a:'{12'h001,12'h001,12'h000,12'h000}, b:'{12'h001,12'h000,12'h000,12'h000}, exp_u:24'h000001, exp_s:24'h000001};
    tbl[2] = '{a:'{12'hFFF,12'hFFF,12'hFFE,12'hFFE}, b:'{12'h800,12'h800,12'h800,12'h801}, exp_u:24'h800FFF, exp_s:24'h800FFF};
    tbl[3] = '{a:'{12'h7FF,12'h800,12'h7FF,12'h800}, b:'{12'h123,12'h456,12'h789,12'hABC}, exp_u:24'h5F0800, exp_s:24'h1F0000};
    tbl[4] = '{a:'{12'h002,12'h000,12'h000,12'h000}, b:'{12'hFFE,12'h000,12'h000,12'h000}, exp_u:24'h400001, exp_s:24'h000001};
    tbl[5] = '{a:'{12'hFFD,12'h000,12'h000,12'h000}, b:'{12'h001,12'h002,12'h003,12'h004}, exp_u:24'h0033FF, exp_s:24'h003FFF};

    rst_n = 1'b1; data_in = '0; in_valid = 1'b0;
    start_a = 1'b0; cont_a = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    pat = 0; tsel = 0; vmode = 0; k0 = '0; k1 = '0;
    for (int d = 0; d < 4; d++) last_exp[d] = '0;
    clear_model();

    // asynchronous reset state, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("reset_dout%0d", d), 64'(dout[d]), 64'd0);
    chk("reset_in_ready", 64'(rdy), 64'd0);
    chk("reset_busy", 64'(bsy), 64'd0);
    chk("reset_done", 64'(dn), 64'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    // table-driven vectors on the N=4 DUTs
    for (int i = 0; i < 6; i++) begin
      pat = 2; tsel = i; vmode = 0;
      pulse_start(1);
      feed(1, 4, st);
      in_valid = 1'b0;
      wait_cycles(4);
      chk($sformatf("tbl%0d_busy_after", i), 64'(bsy[3:2]), 64'd0);
      chk($sformatf("tbl%0d_hold_u", i), 64'(dout[2]), 64'(last_exp[2]));
      chk($sformatf("tbl%0d_hold_s", i), 64'(dout[3]), 64'(last_exp[3]));
    end

    // step 0x7FF/0x800 block, with START/CONT poked mid-block
    pat = 1; k1 = 12'h800; vmode = 0;
    pulse_start(0);
    feed(0, 300, st);
    in_valid = 1'b0;
    start_a = 1'b1; cont_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; cont_a = 1'b0;
    feed(0, 724, st);
    in_valid = 1'b0;
    wait_cycles(4);
    chk("step_busy_after", 64'(bsy[1:0]), 64'd0);

    // full-scale / minimum constants with IN_VALID toggling
    pat = 0; k0 = 12'hFFF; k1 = 12'h001; vmode = 1;
    pulse_start(0);
    feed(0, 1024, st);
    in_valid = 1'b0;
    wait_cycles(20);
    chk("fullscale_hold_u", 64'(dout[0]), 64'(last_exp[0]));
    chk("fullscale_hold_s", 64'(dout[1]), 64'(last_exp[1]));

    // continuous mode: three blocks, CONT dropped during the third
    vmode = 0;
    @(negedge clk); cont_a = 1'b1;
    @(posedge clk); #1;
    k0 = 12'h100; k1 = 12'hE00;
    feed(0, 1024, st);
    chk("cont_blk1_stalls", 64'(st), 64'd0);
    k0 = 12'h200; k1 = 12'h0F0;
    feed(0, 1024, st);
    chk("cont_blk2_stalls", 64'(st), 64'd1);
    k0 = 12'h300; k1 = 12'h801;
    feed(0, 100, st);
    cont_a = 1'b0;
    feed(0, 924, st2);
    chk("cont_blk3_stalls", 64'(st + st2), 64'd1);
    wait_cycles(4);
    chk("cont_end_busy", 64'(bsy[1:0]), 64'd0);
    chk("cont_end_ready", 64'(rdy[1:0]), 64'd0);
    in_valid = 1'b0;

    // reset in the middle of a block
    pat = 3;
    pulse_start(0);
    feed(0, 600, st);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_dout_u", 64'(dout[0]), 64'd0);
    chk("midrst_dout_s", 64'(dout[1]), 64'd0);
    chk("midrst_ready", 64'(rdy[1:0]), 64'd0);
    chk("midrst_busy", 64'(bsy[1:0]), 64'd0);
    chk("midrst_done", 64'(dn), 64'd0);
    clear_model();
    for (int d = 0; d < 4; d++) last_exp[d] = '0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(5);
    chk("postrst_idle_busy", 64'(bsy[1:0]), 64'd0);
    chk("postrst_dout_u", 64'(dout[0]), 64'd0);
    pat = 0; k0 = 12'h123; k1 = 12'h321;
    pulse_start(0);
    feed(0, 1024, st);
    in_valid = 1'b0;
    wait_cycles(4);
    chk("postrst_busy_after", 64'(bsy[1:0]), 64'd0);

    for (int d = 0; d < 4; d++)
      chk($sformatf("dut%0d_pending_results", d), 64'(sq[d].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_multi_average.md
ADC_MULTI_AVERAGE -- requirements
Module: ADC_MULTI_AVERAGE

Interface
REQ-001 Parameter ADC_WIDTH, default 12: bits per ADC sample per channel.
REQ-002 Parameter NUM_CH, default 2: number of channels averaged in parallel, range 1..8.
REQ-003 Parameter LOG2_SAMPS, default 10: block length N = 2^LOG2_SAMPS samples per channel, range 1..16.
REQ-004 Parameter SIGNED_MODE, default 0: 0 = unsigned/offset-binary samples, 1 = two's-complement samples.
REQ-005 CLK  input  1  sole clock; all registers on rising edge.
REQ-006 RST  input  1  reset, asynchronous assert, active-low (RST=0 resets).
REQ-007 DATA_IN  input  NUM_CH*ADC_WIDTH  packed samples, channel c at bits [c*ADC_WIDTH +: ADC_WIDTH].
REQ-008 IN_VALID  input  1  DATA_IN holds a sample set this cycle.
REQ-009 IN_READY  output  1  block accepts a sample set this cycle.
REQ-010 START  input  1  arm one averaging block (sampled in IDLE only).
REQ-011 CONT  input  1  continuous mode: start a new block automatically after each completed block.
REQ-012 BUSY  output  1  high in any state other than IDLE.
REQ-013 DATA_OUT  output  NUM_CH*ADC_WIDTH  per-channel rounded averages, same packing and encoding as DATA_IN.
REQ-014 DONE  output  1  one-cycle pulse: DATA_OUT updated with a new result.

Function
REQ-015 States SHALL be IDLE, ACCUM, LATCH; encoding is free.
REQ-016 A sample set SHALL be accepted on a rising edge where IN_VALID=1 and IN_READY=1; IN_READY SHALL be 1 exactly in ACCUM.
REQ-017 IDLE -> ACCUM when START=1 or CONT=1; on that edge all accumulators and the sample counter SHALL clear to 0.
REQ-018 START or CONT high while BUSY=1 SHALL NOT restart or disturb the block in progress.
REQ-019 In ACCUM, each accepted set SHALL add each channel's sample (zero-extended if SIGNED_MODE=0, sign-extended if 1) to that channel's accumulator and increment the counter; IN_VALID=0 stalls with no change.
REQ-020 Accumulators SHALL be ADC_WIDTH+LOG2_SAMPS bits so N full-scale samples never overflow.
REQ-021 On the edge accepting the Nth set, state SHALL go ACCUM -> LATCH.
REQ-022 On the LATCH exit edge, DATA_OUT[c] SHALL load (acc[c] + 2^(LOG2_SAMPS-1)) >>> LOG2_SAMPS (round half up; arithmetic shift in signed mode), truncated to ADC_WIDTH bits; DONE SHALL be 1 for exactly the following cycle.
REQ-023 Result latency: DATA_OUT/DONE valid 1 cycle after the edge accepting the Nth set.
REQ-024 LATCH exit: CONT=1 -> ACCUM with accumulators/counter cleared; CONT=0 -> IDLE (START ignored in LATCH).
REQ-025 In continuous mode exactly one cycle per block SHALL have IN_READY=0 (the LATCH cycle); data offered then is not accepted.
REQ-026 DATA_OUT SHALL hold its value between DONE pulses, including across IDLE periods.
REQ-027 CONT falling during ACCUM SHALL let the current block complete, then return to IDLE.

Reset
REQ-028 RST=0 SHALL immediately force state IDLE, accumulators/counter 0, DATA_OUT 0, DONE 0, IN_READY 0, BUSY 0, independent of CLK.
REQ-029 Reset mid-block SHALL discard the partial block; no DONE for it; first block after release requires START or CONT.
REQ-030 Release of RST SHALL be synchronous to CLK by the integrating design; the block requires no extra deassert behaviour.

Verification
REQ-031 Unsigned, NUM_CH=1, LOG2_SAMPS=10, START pulse, 512 sets 0x7FF then 512 sets 0x800, IN_VALID=1 -> one DONE, DATA_OUT=0x800 (2047.5 rounds up), 1 cycle after 1024th accept.
REQ-032 Same stimulus with SIGNED_MODE=1 -> DATA_OUT=0x000 (-0.5 rounds up to 0); second run with all 0x800 -> 0x800 (-2048).
REQ-033 NUM_CH=2, ch0 constant 0xFFF, ch1 constant 0x001, IN_VALID toggling every other cycle -> DONE after 1024 accepts only, DATA_OUT={0x001,0xFFF}, no overflow.
REQ-034 CONT=1, IN_VALID held 1, three blocks of constant values 0x100, 0x200, 0x300 -> DONE pulses spaced N+1 cycles, outputs 0x100, 0x200, 0x300, IN_READY low one cycle per block.
REQ-035 RST=0 asserted after 600 accepts, released, START -> no DONE for aborted block; next block of constant 0x123 yields 0x123; outputs 0 during reset.
